// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file widths and architectural register indices
package mips_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read ports, two writeback ports and load-scoreboard signals
interface regfile_mp_sb_if #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W,
  parameter int ADDR_W = mips_pkg::DEF_ADDR_W,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0] rd_pending;
  logic we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic [ADDR_W:0] pending_cnt;
  modport master (
    output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    input rd_data, rd_pending, pending_cnt
  );
  modport slave (
    input rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, sb_set, sb_addr,
    output rd_data, rd_pending, pending_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register load-pending bits, their count and per-port lookup
module regfile_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  input  logic i_we1,
  input  logic [ADDR_W-1:0] i_waddr1,
  input  logic i_sb_set,
  input  logic [ADDR_W-1:0] i_sb_addr,
  output logic [NUM_RD-1:0] o_rd_pending,
  output logic [ADDR_W:0] o_pending_cnt
);
  import mips_pkg::*;
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] r_pending, w_pending_nxt;
  logic [ADDR_W:0] r_cnt, w_cnt_nxt;
  logic w_set;
  assign w_set = i_sb_set && !(ZERO_REG != 0 && i_sb_addr == ADDR_W'(REG_ZERO));
  // a load writeback clears its bit, but a reissued load to the same register sets it again
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_we1) w_pending_nxt[i_waddr1] = 1'b0;
    if (w_set) w_pending_nxt[i_sb_addr] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_pending_nxt[i]);
  end
  // pending bits and their count move together so the count always matches the bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  // a bypassed same-cycle load writeback already satisfies the reader, so it is not pending
  always_comb begin
    o_rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++)
      o_rd_pending[k] = r_pending[i_rd_addr[k*ADDR_W +: ADDR_W]] &&
                        !(BYPASS != 0 && i_we1 && i_waddr1 == i_rd_addr[k*ADDR_W +: ADDR_W]);
  end
  assign o_pending_cnt = r_cnt;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read register file with ALU and load writeback ports, bypass and scoreboard
module regfile_mp_sb #(
  parameter int DATA_W = mips_pkg::DEF_DATA_W,
  parameter int ADDR_W = mips_pkg::DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  regfile_mp_sb_if.slave bus
);
  import mips_pkg::*;
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] w_ra [NUM_RD];
  logic w_we0, w_we1, w_byp;
  assign w_we0 = bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == ADDR_W'(REG_ZERO));
  assign w_we1 = bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == ADDR_W'(REG_ZERO));
  assign w_byp = (BYPASS != 0) && rst;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign w_ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end
  // storage; the load port is written last so it wins a same-address collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we0) r_mem[bus.waddr0] <= bus.wdata0;
      if (w_we1) r_mem[bus.waddr1] <= bus.wdata1;
    end
  end
  // read muxing: zero register first, then load bypass over ALU bypass over storage
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++)
      bus.rd_data[k*DATA_W +: DATA_W] =
        (ZERO_REG != 0 && w_ra[k] == ADDR_W'(REG_ZERO)) ? {DATA_W{1'b0}} :
        (w_byp && bus.we1 && bus.waddr1 == w_ra[k]) ? bus.wdata1 :
        (w_byp && bus.we0 && bus.waddr0 == w_ra[k]) ? bus.wdata0 : r_mem[w_ra[k]];
  end
  regfile_scoreboard #(
    .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .i_rd_addr(bus.rd_addr),
    .i_we1(bus.we1),
    .i_waddr1(bus.waddr1),
    .i_sb_set(bus.sb_set),
    .i_sb_addr(bus.sb_addr),
    .o_rd_pending(bus.rd_pending),
    .o_pending_cnt(bus.pending_cnt)
  );
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the core's 32x32 register file.
- Adds:
  - a configurable number of read ports;
  - a second write port for memory/load writeback;
  - optional same-cycle write-to-read bypass;
  - hardwired-zero register 0;
  - a per-register pending scoreboard for long-latency loads.
- Sits in the decode stage. Decode stalls on any asserted rd_pending bit.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, and writes/sb_set to it are ignored
- BYPASS, 1, 1 = reads see same-cycle write data combinationally

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_pending  out  NUM_RD  1 = addressed register awaits a load writeback
- we0  in  1  ALU writeback enable
- waddr0  in  ADDR_W  ALU writeback address
- wdata0  in  DATA_W  ALU writeback data
- we1  in  1  load writeback enable; also clears that register's pending bit
- waddr1  in  ADDR_W  load writeback address
- wdata1  in  DATA_W  load writeback data
- sb_set  in  1  load issued: mark sb_addr pending
- sb_addr  in  ADDR_W  destination of the issued load
- pending_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (rst=0, asynchronous):
  - all DEPTH registers := 0;
  - all pending bits := 0;
  - pending_cnt := 0.
  - rd_data therefore reads 0 and rd_pending reads 0 while in reset.
  - Reset mid-operation discards any in-flight write and all pending state.
- Writes:
  - Take effect on the rising clk edge.
  - Without bypass, the written value is visible on reads in the following cycle.
- Dual write, same address (we0 & we1, waddr0==waddr1): port 1 wins; wdata1 is stored.
- ZERO_REG=1:
  - Writes to address 0 are dropped on both ports.
  - sb_set to address 0 is dropped.
  - Reads of address 0 return 0 and rd_pending=0, regardless of BYPASS.
- Read data (per port k, combinational):
  - If BYPASS=1 and we1 & waddr1==rd_addr_k: wdata1.
  - Else if BYPASS=1 and we0 & waddr0==rd_addr_k: wdata0.
  - Else: the stored value.
- Scoreboard, per register next-state on clk edge:
  - sb_set & sb_addr==r: pending[r] := 1. Set wins over a same-cycle clear; this models a new load reissuing to the register.
  - Else if we1 & waddr1==r: pending[r] := 0.
  - Otherwise pending[r] holds.
  - we0 does not touch pending bits.
- rd_pending per port k, combinational:
  - = pending[rd_addr_k].
  - When BYPASS=1, forced to 0 if we1 & waddr1==rd_addr_k in the same cycle.
- pending_cnt:
  - Equals the population count of the pending bits after the edge, i.e. same-cycle as the registered bits.
  - Range 0..DEPTH (or 0..DEPTH-1 with ZERO_REG); no wrap.
- Out-of-range or X addresses are not possible; all ADDR_W codes are valid.
- No handshakes beyond the above. Single-cycle throughput on every port; all NUM_RD reads are independent.

Decomposition:
- Shared package (mips_pkg): DATA_W/ADDR_W defaults, REG_ZERO constant, register-index names (e.g. REG_SP=29, REG_RA=31).
- One sub-module, regfile_scoreboard: pending bit vector, set/clear priority, pending_cnt popcount, per-port rd_pending lookup.
- Storage, write priority and bypass muxing stay in regfile_mp_sb.

Test Plan:
- Reset:
  - Stimulus: write 0xDEADBEEF to r5, sb_set r7, then pulse rst low between clock edges.
  - Required response: r5 reads 0, rd_pending for r7 is 0, pending_cnt=0 immediately, without waiting for a clock edge.
- Dual-write conflict:
  - Stimulus: same cycle we0 r9=0x11111111 and we1 r9=0x22222222.
  - Required response: next cycle r9 reads 0x22222222. With BYPASS=1, the same-cycle read also returns 0x22222222.
- Zero register (ZERO_REG=1):
  - Stimulus: we0 r0=0xFFFFFFFF, sb_set r0.
  - Required response: r0 reads 0, rd_pending=0, pending_cnt stays 0.
- Scoreboard set/clear:
  - Stimulus: sb_set r3 → rd_pending=1, pending_cnt=1. Two cycles later, we1 r3=0xCAFE0003.
  - Required response: with BYPASS=1, that cycle rd_pending=0 and rd_data=0xCAFE0003. Next cycle pending_cnt=0.
- Set/clear collision:
  - Stimulus: sb_set r4 with we1 r4=0x44 in the same cycle, after r4 was already pending.
  - Required response: r4 stores 0x44, pending stays 1, pending_cnt unchanged.
- Bypass disabled, NUM_RD=3:
  - Stimulus: we0 r2=0x12345678, with all three read ports addressing r2 that cycle.
  - Required response: old value that cycle, 0x12345678 next cycle on all three ports.
